// File: rtl/ttl_reg_latch_pair.sv
// Hex D flip-flop bank with clear (74S174-style) paired with an octal transparent latch
// with output enable (74S373-style). Define TTL_TRISTATE_EN for a high-impedance bus.
module ttl_reg_latch_pair (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_n,
  input  logic [5:0] d,
  output logic [5:0] q,
  input  logic       hold_n,
  input  logic       oenb_n,
  input  logic [7:0] i,
  output logic [7:0] o
);

  logic [5:0] q_q, q_d;
  logic [7:0] lat_q, lat_d;
  logic [7:0] data;

  always_comb begin
    q_d = q_q;
    if (!clr_n) begin
      q_d = 6'h00;
    end else begin
      q_d = d;
    end
  end

  always_comb begin
    lat_d = lat_q;
    if (hold_n) begin
      lat_d = i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q   <= 6'h00;
      lat_q <= 8'h00;
    end else begin
      q_q   <= q_d;
      lat_q <= lat_d;
    end
  end

  // Transparent mode bypasses the store so o follows i with no clock delay.
  always_comb begin
    data = hold_n ? i : lat_q;
  end

  assign q = q_q;

`ifdef TTL_TRISTATE_EN
  assign o = oenb_n ? 8'bzzzz_zzzz : data;
`else
  assign o = oenb_n ? 8'h00 : data;
`endif

endmodule

// File: tb/tb_ttl_reg_latch_pair.sv
// Bench for ttl_reg_latch_pair: directed vector table, hand sequences, then random stimulus
// against a behavioural model. Honours TTL_TRISTATE_EN for the disabled-bus value.
module tb_ttl_reg_latch_pair;

  logic       clock;
  logic       reset;
  logic       clr_n;
  logic [5:0] d;
  logic [5:0] q;
  logic       hold_n;
  logic       oenb_n;
  logic [7:0] i;
  logic [7:0] o;

  int total;
  int bad;

`ifdef TTL_TRISTATE_EN
  localparam logic [7:0] Dis = 8'bzzzz_zzzz;
`else
  localparam logic [7:0] Dis = 8'h00;
`endif

  ttl_reg_latch_pair dut (
    .clock  (clock),
    .reset  (reset),
    .clr_n  (clr_n),
    .d      (d),
    .q      (q),
    .hold_n (hold_n),
    .oenb_n (oenb_n),
    .i      (i),
    .o      (o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       clr_n;
    logic [5:0] d;
    logic       hold_n;
    logic       oenb_n;
    logic [7:0] i;
    logic [5:0] q_exp;
    logic [7:0] o_exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk_q(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: q got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_o(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: o got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: what the flip-flops and latch store should hold.
  logic [5:0] m_q;
  logic [7:0] m_lat;

  function automatic logic [7:0] model_o(input logic hn, input logic oe, input logic [7:0] iv,
                                         input logic [7:0] lat);
    if (oe) return Dis;
    return hn ? iv : lat;
  endfunction

  initial begin
    reset  = 1'b1;
    clr_n  = 1'b1;
    d      = 6'h3F;
    hold_n = 1'b0;
    oenb_n = 1'b0;
    i      = 8'h00;
    total  = 0;
    bad    = 0;

    //          rst   clr   d      hold  oenb  i       q      o
    vecs[0]  = '{1'b1, 1'b1, 6'h3F, 1'b0, 1'b0, 8'h00, 6'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 6'h01, 1'b0, 1'b0, 8'hFF, 6'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 8'hFF, 6'h01, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 6'h02, 1'b1, 1'b0, 8'hA5, 6'h02, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 6'h03, 1'b0, 1'b0, 8'h00, 6'h03, 8'hA5};
    vecs[5]  = '{1'b0, 1'b1, 6'h03, 1'b0, 1'b1, 8'h3C, 6'h03, Dis};
    vecs[6]  = '{1'b0, 1'b1, 6'h03, 1'b0, 1'b0, 8'h3C, 6'h03, 8'hA5};
    vecs[7]  = '{1'b0, 1'b1, 6'h04, 1'b1, 1'b0, 8'h5A, 6'h04, 8'h5A};
    vecs[8]  = '{1'b0, 1'b0, 6'h2A, 1'b0, 1'b0, 8'h00, 6'h00, 8'h5A};
    vecs[9]  = '{1'b0, 1'b1, 6'h2A, 1'b1, 1'b0, 8'h5A, 6'h2A, 8'h5A};
    vecs[10] = '{1'b0, 1'b1, 6'h2A, 1'b0, 1'b0, 8'h11, 6'h2A, 8'h5A};
    vecs[11] = '{1'b1, 1'b1, 6'h15, 1'b0, 1'b0, 8'h77, 6'h00, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 6'h15, 1'b0, 1'b0, 8'h77, 6'h00, 8'h00};

    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      reset  = vecs[k].rst;
      clr_n  = vecs[k].clr_n;
      d      = vecs[k].d;
      hold_n = vecs[k].hold_n;
      oenb_n = vecs[k].oenb_n;
      i      = vecs[k].i;
      @(posedge clock);
      #1;
      chk_q($sformatf("vec%0d", k), q, vecs[k].q_exp);
      chk_o($sformatf("vec%0d", k), o, vecs[k].o_exp);
    end

    // Clear then load; d changing mid-cycle must not reach q until the next edge.
    @(negedge clock);
    reset = 1'b0; clr_n = 1'b0; d = 6'h01; hold_n = 1'b0; oenb_n = 1'b0; i = 8'h00;
    @(posedge clock); #1;
    chk_q("clr_hold_zero", q, 6'h00);
    @(negedge clock);
    clr_n = 1'b1;
    @(posedge clock); #1;
    chk_q("load_01", q, 6'h01);
    #2 d = 6'h00;
    #1 chk_q("no_comb_path", q, 6'h01);
    @(posedge clock); #1;
    chk_q("load_00", q, 6'h00);

    // Transparency without any clock edge in between.
    @(negedge clock);
    hold_n = 1'b1; oenb_n = 1'b0;
    i = 8'h01; #1 chk_o("transp_01", o, 8'h01);
    i = 8'h00; #1 chk_o("transp_00", o, 8'h00);
    i = 8'h01; #1 chk_o("transp_01b", o, 8'h01);
    oenb_n = 1'b1; #1 chk_o("oe_off", o, Dis);
    oenb_n = 1'b0; #1 chk_o("oe_on", o, 8'h01);

    // Capture A5, then hold across several edges while i moves.
    @(negedge clock);
    i = 8'hA5;
    @(posedge clock);
    @(negedge clock);
    hold_n = 1'b0; i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk_o($sformatf("hold_a5_%0d", k), o, 8'hA5);
    end
    @(negedge clock);
    hold_n = 1'b1; #1 chk_o("release", o, 8'h00);

    // Randomised phase against the model.
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    m_q = 6'h00;
    m_lat = 8'h00;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      reset  = ($urandom_range(0, 19) == 0);
      clr_n  = ($urandom_range(0, 4) != 0);
      d      = 6'($urandom);
      hold_n = $urandom_range(0, 1) == 1;
      oenb_n = ($urandom_range(0, 3) == 0);
      i      = 8'($urandom);
      #1 chk_o("rnd_comb", o, model_o(hold_n, oenb_n, i, m_lat));
      @(posedge clock);
      if (reset) begin
        m_q = 6'h00;
        m_lat = 8'h00;
      end else begin
        m_q = clr_n ? d : 6'h00;
        if (hold_n) m_lat = i;
      end
      #1;
      chk_q("rnd_q", q, m_q);
      chk_o("rnd_o", o, model_o(hold_n, oenb_n, i, m_lat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
